// File: rtl/bf_pkg.sv
// bf_pkg: shared definitions for the Brainfuck-style sequencer.
//   - opcode byte values decoded by the sequencer
//   - bf_state_e: sequencer FSM states
package bf_pkg;

    localparam logic [7:0] OP_PTR_INC  = 8'h3E;  // '>'
    localparam logic [7:0] OP_PTR_DEC  = 8'h3C;  // '<'
    localparam logic [7:0] OP_CELL_INC = 8'h2B;  // '+'
    localparam logic [7:0] OP_CELL_DEC = 8'h2D;  // '-'
    localparam logic [7:0] OP_OUT      = 8'h2E;  // '.'
    localparam logic [7:0] OP_IN       = 8'h2C;  // ','
    localparam logic [7:0] OP_LOOP     = 8'h5B;  // '['
    localparam logic [7:0] OP_END_LOOP = 8'h5D;  // ']'
    localparam logic [7:0] OP_END      = 8'h00;  // program end

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        SKIP_F,
        SKIP_E,
        WAIT_IN,
        WAIT_OUT,
        HALT
    } bf_state_e;

endpackage

// File: rtl/bf_ret_stack.sv
// bf_ret_stack: synchronous LIFO of loop return addresses.
//   clk, rst   : clock, synchronous active-high reset (clears sp only)
//   push       : write push_data on top (ignored when full)
//   pop        : drop the top entry (ignored when empty)
//   push_data  : address to push
//   top        : entry at sp-1 (undefined when empty)
//   sp         : number of valid entries, 0..DEPTH
//   full/empty : sp == DEPTH / sp == 0
module bf_ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int SP_W  = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    push_data,
    output logic [W-1:0]    top,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty
);

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp_m1;

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign sp_m1 = sp - SP_W'(1);
    assign top   = mem[sp_m1[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end

    // NOTE: storage has no reset; entries above sp are never read, so only sp needs clearing.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bf_sequencer.sv
// bf_sequencer: fetches opcodes from a synchronous program ROM, issues
// one-cycle tape strobes, resolves loops via bf_ret_stack and moves bytes
// to/from the host over valid/ready handshakes.
//   clk, rst             : clock, synchronous active-high reset
//   prog_addr/prog_data  : ROM address (registered pc) / opcode one cycle later
//   cell_rdata           : current tape cell value
//   ptr_step/ptr_dir     : pointer move pulse, 0 = inc, 1 = dec
//   cell_step/cell_dir   : cell value step pulse, 0 = inc, 1 = dec
//   cell_we/cell_wdata   : cell write pulse and data (from host input)
//   in_data/in_valid/in_ready    : host input handshake
//   out_data/out_valid/out_ready : host output handshake
//   halted, fault        : sticky status
module bf_sequencer
    import bf_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 8,
    parameter int NEST_W      = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] prog_addr,
    input  logic [7:0]      prog_data,
    input  logic [7:0]      cell_rdata,
    output logic            ptr_step,
    output logic            ptr_dir,
    output logic            cell_step,
    output logic            cell_dir,
    output logic            cell_we,
    output logic [7:0]      cell_wdata,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [7:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            halted,
    output logic            fault
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    bf_state_e       state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [NEST_W-1:0] nest, nest_n;
    logic [7:0]      out_data_q, out_data_n;
    logic            halted_q, halted_n;
    logic            fault_q, fault_n;

    // Stack interface
    logic            push, pop;
    logic [PC_W-1:0] stk_top;
    logic [SP_W-1:0] stk_sp;
    logic            stk_full, stk_empty;

    // Sequencing helpers: adv requests pc+1 then adv_state; trap halts with fault.
    logic            adv;
    bf_state_e       adv_state;
    logic            trap;
    logic            cell_nz;

    bf_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc),
        .top       (stk_top),
        .sp        (stk_sp),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign cell_nz    = (cell_rdata != 8'd0);
    assign prog_addr  = pc;
    assign cell_wdata = in_data;
    assign out_data   = out_data_q;
    assign out_valid  = (state == WAIT_OUT);
    assign halted     = halted_q;
    assign fault      = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= '0;
            nest       <= '0;
            out_data_q <= 8'd0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            nest       <= nest_n;
            out_data_q <= out_data_n;
            halted_q   <= halted_n;
            fault_q    <= fault_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        nest_n     = nest;
        out_data_n = out_data_q;
        halted_n   = halted_q;
        fault_n    = fault_q;
        push       = 1'b0;
        pop        = 1'b0;
        ptr_step   = 1'b0;
        ptr_dir    = 1'b0;
        cell_step  = 1'b0;
        cell_dir   = 1'b0;
        cell_we    = 1'b0;
        in_ready   = 1'b0;
        adv        = 1'b0;
        adv_state  = FETCH;
        trap       = 1'b0;

        case (state)
            FETCH: state_n = EXEC;

            EXEC: begin
                case (prog_data)
                    OP_PTR_INC:  begin ptr_step = 1'b1; adv = 1'b1; end
                    OP_PTR_DEC:  begin ptr_step = 1'b1; ptr_dir = 1'b1; adv = 1'b1; end
                    OP_CELL_INC: begin cell_step = 1'b1; adv = 1'b1; end
                    OP_CELL_DEC: begin cell_step = 1'b1; cell_dir = 1'b1; adv = 1'b1; end
                    OP_OUT: begin
                        out_data_n = cell_rdata;
                        state_n    = WAIT_OUT;
                    end
                    OP_IN: state_n = WAIT_IN;
                    OP_LOOP: begin
                        if (cell_nz) begin
                            if (stk_full) begin
                                trap = 1'b1;
                            end else begin
                                push = 1'b1;
                                adv  = 1'b1;
                            end
                        end else begin
                            // Skip forward to the matching ']' with bracket depth 1.
                            nest_n    = NEST_W'(1);
                            adv       = 1'b1;
                            adv_state = SKIP_F;
                        end
                    end
                    OP_END_LOOP: begin
                        if (stk_empty) begin
                            trap = 1'b1;
                        end else if (cell_nz) begin
                            // Jump to the body start; the '[' entry stays on the stack.
                            if (&stk_top) begin
                                trap = 1'b1;
                            end else begin
                                pc_n    = stk_top + PC_W'(1);
                                state_n = FETCH;
                            end
                        end else begin
                            pop = 1'b1;
                            adv = 1'b1;
                        end
                    end
                    OP_END: begin
                        halted_n = 1'b1;
                        state_n  = HALT;
                    end
                    default: adv = 1'b1;
                endcase
            end

            SKIP_F: state_n = SKIP_E;

            SKIP_E: begin
                adv_state = SKIP_F;
                case (prog_data)
                    OP_LOOP: begin
                        if (&nest) begin
                            trap = 1'b1;
                        end else begin
                            nest_n = nest + NEST_W'(1);
                            adv    = 1'b1;
                        end
                    end
                    OP_END_LOOP: begin
                        nest_n = nest - NEST_W'(1);
                        adv    = 1'b1;
                        if (nest == NEST_W'(1)) begin
                            adv_state = FETCH;
                        end
                    end
                    OP_END:  trap = 1'b1;
                    default: adv = 1'b1;
                endcase
            end

            WAIT_OUT: begin
                if (out_ready) begin
                    adv = 1'b1;
                end
            end

            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cell_we = 1'b1;
                    adv     = 1'b1;
                end
            end

            HALT: state_n = HALT;

            default: state_n = HALT;
        endcase

        // A pc increment out of the all-ones address is a fault, not a wrap.
        if (adv) begin
            if (&pc) begin
                trap = 1'b1;
            end else begin
                pc_n    = pc + PC_W'(1);
                state_n = adv_state;
            end
        end

        if (trap) begin
            fault_n  = 1'b1;
            halted_n = 1'b1;
            state_n  = HALT;
        end
    end

endmodule

// File: tb/tb_bf_sequencer.sv
// tb_bf_sequencer: directed tests for bf_sequencer with a behavioural ROM
// and tape; event logger samples DUT outputs on the falling edge.
module tb_bf_sequencer;
    import bf_pkg::*;

    localparam int PC_W        = 8;
    localparam int STACK_DEPTH = 8;
    localparam int NEST_W      = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] prog_addr;
    logic [7:0]      prog_data;
    logic [7:0]      cell_rdata;
    logic            ptr_step, ptr_dir, cell_step, cell_dir, cell_we;
    logic [7:0]      cell_wdata;
    logic [7:0]      in_data = 8'd0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            halted, fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bf_sequencer #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH),
        .NEST_W      (NEST_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .cell_rdata (cell_rdata),
        .ptr_step   (ptr_step),
        .ptr_dir    (ptr_dir),
        .cell_step  (cell_step),
        .cell_dir   (cell_dir),
        .cell_we    (cell_we),
        .cell_wdata (cell_wdata),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .halted     (halted),
        .fault      (fault)
    );

    // Program ROM: one-cycle read latency.
    logic [7:0] rom [256];
    always @(posedge clk) prog_data <= rom[prog_addr];

    // Tape model: 16 cells, pointer wraps.
    logic [7:0] tape [16];
    logic [3:0] ptr;
    assign cell_rdata = tape[ptr];
    always @(posedge clk) begin
        if (rst) begin
            ptr <= 4'd0;
            for (int i = 0; i < 16; i++) tape[i] <= 8'd0;
        end else begin
            if (ptr_step)  ptr <= ptr_dir ? ptr - 4'd1 : ptr + 4'd1;
            if (cell_step) tape[ptr] <= cell_dir ? tape[ptr] - 8'd1 : tape[ptr] + 8'd1;
            if (cell_we)   tape[ptr] <= cell_wdata;
        end
    end

    // Event logger, cleared while rst is high.
    int         cyc = 0;
    bit         cs_dir_q[$];
    int         cs_cyc_q[$];
    int         ps_cnt, we_cnt, ir_cnt, ov_cnt, oh_cnt, back_cnt, nest_max, multi_cnt;
    logic       ps_dir_last, ov_prev, ov_unstable;
    logic [7:0] we_data, oh_data, ov_prev_data;
    logic [PC_W-1:0] prev_addr;

    always @(negedge clk) begin
        if (rst) begin
            cs_dir_q.delete();
            cs_cyc_q.delete();
            ps_cnt = 0; we_cnt = 0; ir_cnt = 0; ov_cnt = 0; oh_cnt = 0;
            back_cnt = 0; nest_max = 0; multi_cnt = 0;
            ps_dir_last = 1'b0; ov_prev = 1'b0; ov_unstable = 1'b0;
            we_data = 8'd0; oh_data = 8'd0; ov_prev_data = 8'd0; prev_addr = '0;
        end else begin
            if (cell_step) begin cs_dir_q.push_back(cell_dir); cs_cyc_q.push_back(cyc); end
            if (ptr_step)  begin ps_cnt++; ps_dir_last = ptr_dir; end
            if (cell_we)   begin we_cnt++; we_data = cell_wdata; end
            if (in_ready)  ir_cnt++;
            if (out_valid) begin
                ov_cnt++;
                if (ov_prev && out_data !== ov_prev_data) ov_unstable = 1'b1;
            end
            if (out_valid && out_ready) begin oh_cnt++; oh_data = out_data; end
            ov_prev = out_valid;
            ov_prev_data = out_data;
            if (prog_addr == 8'd3 && prev_addr == 8'd4) back_cnt++;
            prev_addr = prog_addr;
            if (int'(dut.nest) > nest_max) nest_max = int'(dut.nest);
            if ((int'(ptr_step) + int'(cell_step) + int'(cell_we)) > 1) multi_cnt++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) rom[i] = s[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        if (!halted) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: halted=%0b after %0d cycles, want 1", name, halted, n);
        end
    endtask

    task automatic test_reset();
        load("+");
        do_reset();
        n_cmp++; if (prog_addr !== 8'd0) begin n_bad++; $display("FAIL reset prog_addr: got %0h want 0", prog_addr); end
        n_cmp++; if ({ptr_step, cell_step, cell_we, in_ready, out_valid} !== 5'b0) begin n_bad++; $display("FAIL reset strobes: got %05b want 00000", {ptr_step, cell_step, cell_we, in_ready, out_valid}); end
        n_cmp++; if ({halted, fault} !== 2'b00) begin n_bad++; $display("FAIL reset status: got %02b want 00", {halted, fault}); end
        n_cmp++; if (out_data !== 8'd0) begin n_bad++; $display("FAIL reset out_data: got %0h want 0", out_data); end
        n_cmp++; if (dut.state !== FETCH) begin n_bad++; $display("FAIL reset state: got %0d want FETCH", dut.state); end
    endtask

    task automatic test_output();
        load("+++.");
        do_reset();
        out_ready = 1'b1;
        run_to_halt("output", 100);
        n_cmp++; if (cs_dir_q.size() !== 3) begin n_bad++; $display("FAIL output step_count: got %0d want 3", cs_dir_q.size()); end
        if (cs_dir_q.size() == 3) begin
            n_cmp++; if ({cs_dir_q[0], cs_dir_q[1], cs_dir_q[2]} !== 3'b000) begin n_bad++; $display("FAIL output step_dirs: got %03b want 000", {cs_dir_q[0], cs_dir_q[1], cs_dir_q[2]}); end
            n_cmp++; if (cs_cyc_q[1] - cs_cyc_q[0] !== 2 || cs_cyc_q[2] - cs_cyc_q[1] !== 2) begin n_bad++; $display("FAIL output step_spacing: got %0d,%0d want 2,2", cs_cyc_q[1] - cs_cyc_q[0], cs_cyc_q[2] - cs_cyc_q[1]); end
        end
        n_cmp++; if (oh_cnt !== 1 || oh_data !== 8'd3) begin n_bad++; $display("FAIL output byte: got count %0d data %0h want 1 / 03", oh_cnt, oh_data); end
        n_cmp++; if ({halted, fault} !== 2'b10) begin n_bad++; $display("FAIL output status: got %02b want 10", {halted, fault}); end
        n_cmp++; if (multi_cnt !== 0) begin n_bad++; $display("FAIL output strobe_overlap: got %0d want 0", multi_cnt); end
    endtask

    task automatic test_io();
        int n;
        load(",.");
        do_reset();
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL io in_ready_wait: got %0b want 1", in_ready); end
        repeat (4) tick();
        in_data = 8'h41;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data = 8'h00;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin n_bad++; $display("FAIL io out_offer: got valid %0b data %0h want 1 / 41", out_valid, out_data); end
        repeat (3) tick();
        out_ready = 1'b1;
        run_to_halt("io", 50);
        n_cmp++; if (ir_cnt !== 5) begin n_bad++; $display("FAIL io in_ready_cycles: got %0d want 5", ir_cnt); end
        n_cmp++; if (we_cnt !== 1 || we_data !== 8'h41) begin n_bad++; $display("FAIL io cell_we: got count %0d data %0h want 1 / 41", we_cnt, we_data); end
        n_cmp++; if (ov_cnt !== 4 || ov_unstable !== 1'b0) begin n_bad++; $display("FAIL io out_hold: got cycles %0d unstable %0b want 4 / 0", ov_cnt, ov_unstable); end
        n_cmp++; if (oh_cnt !== 1 || oh_data !== 8'h41) begin n_bad++; $display("FAIL io out_byte: got count %0d data %0h want 1 / 41", oh_cnt, oh_data); end
        n_cmp++; if ({halted, fault} !== 2'b10) begin n_bad++; $display("FAIL io status: got %02b want 10", {halted, fault}); end
    endtask

    task automatic test_loop();
        bit exp_dir [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        load("++[-]");
        do_reset();
        run_to_halt("loop", 200);
        n_cmp++; if (cs_dir_q.size() !== 4) begin n_bad++; $display("FAIL loop step_count: got %0d want 4", cs_dir_q.size()); end
        for (int i = 0; i < 4 && i < cs_dir_q.size(); i++) begin
            n_cmp++; if (cs_dir_q[i] !== exp_dir[i]) begin n_bad++; $display("FAIL loop step_dir[%0d]: got %0b want %0b", i, cs_dir_q[i], exp_dir[i]); end
        end
        n_cmp++; if (back_cnt !== 1) begin n_bad++; $display("FAIL loop jump_back: got %0d want 1", back_cnt); end
        n_cmp++; if (dut.u_stack.sp !== 4'd0) begin n_bad++; $display("FAIL loop sp_final: got %0d want 0", dut.u_stack.sp); end
        n_cmp++; if ({halted, fault} !== 2'b10) begin n_bad++; $display("FAIL loop status: got %02b want 10", {halted, fault}); end
        n_cmp++; if (multi_cnt !== 0) begin n_bad++; $display("FAIL loop strobe_overlap: got %0d want 0", multi_cnt); end
    endtask

    task automatic test_skip();
        load("[[+]>]<");
        do_reset();
        run_to_halt("skip", 200);
        n_cmp++; if (cs_dir_q.size() !== 0) begin n_bad++; $display("FAIL skip cell_steps: got %0d want 0", cs_dir_q.size()); end
        n_cmp++; if (ps_cnt !== 1 || ps_dir_last !== 1'b1) begin n_bad++; $display("FAIL skip ptr_step: got count %0d dir %0b want 1 / 1", ps_cnt, ps_dir_last); end
        n_cmp++; if (nest_max !== 2 || dut.nest !== 8'd0) begin n_bad++; $display("FAIL skip nest: got max %0d final %0d want 2 / 0", nest_max, dut.nest); end
        n_cmp++; if ({halted, fault} !== 2'b10) begin n_bad++; $display("FAIL skip status: got %02b want 10", {halted, fault}); end
    endtask

    task automatic test_faults();
        load("]");
        do_reset();
        run_to_halt("underflow", 50);
        n_cmp++; if ({halted, fault} !== 2'b11) begin n_bad++; $display("FAIL underflow status: got %02b want 11", {halted, fault}); end
        repeat (4) tick();
        n_cmp++; if ({in_ready, out_valid} !== 2'b00 || (ps_cnt + we_cnt + cs_dir_q.size()) !== 0) begin n_bad++; $display("FAIL halt_quiet: got ready/valid %02b strobes %0d want 00 / 0", {in_ready, out_valid}, ps_cnt + we_cnt + cs_dir_q.size()); end

        load("+[[[[[[[[[");
        do_reset();
        run_to_halt("overflow", 200);
        n_cmp++; if ({halted, fault} !== 2'b11) begin n_bad++; $display("FAIL overflow status: got %02b want 11", {halted, fault}); end
        n_cmp++; if (prog_addr !== 8'd9 || dut.u_stack.sp !== 4'd8) begin n_bad++; $display("FAIL overflow where: got pc %0d sp %0d want 9 / 8", prog_addr, dut.u_stack.sp); end

        load("[");
        do_reset();
        run_to_halt("unmatched", 50);
        n_cmp++; if ({halted, fault} !== 2'b11) begin n_bad++; $display("FAIL unmatched status: got %02b want 11", {halted, fault}); end
    endtask

    task automatic test_reset_mid_out();
        int n;
        load("+.");
        do_reset();
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'd1) begin n_bad++; $display("FAIL midreset offer: got valid %0b data %0h want 1 / 01", out_valid, out_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (prog_addr !== 8'd0 || out_valid !== 1'b0 || out_data !== 8'd0) begin n_bad++; $display("FAIL midreset outputs: got pc %0d valid %0b data %0h want 0 / 0 / 00", prog_addr, out_valid, out_data); end
        n_cmp++; if ({halted, fault} !== 2'b00 || dut.state !== FETCH) begin n_bad++; $display("FAIL midreset state: got status %02b state %0d want 00 / FETCH", {halted, fault}, dut.state); end
    endtask

    initial begin
        test_reset();
        test_output();
        test_io();
        test_loop();
        test_skip();
        test_faults();
        test_reset_mid_out();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
